// File: rtl/sensor_mon_pkg.sv
// sensor_mon_pkg: shared FSM state type and default fault-rule masks for sensor_fault_monitor
package sensor_mon_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, FAULT} state_e;
  localparam int DEF_NUM_SENSORS = 4;
  localparam logic [3:0] DEF_CRIT_MASK = 4'b0001;
  localparam logic [3:0] DEF_PAIR_MASK = 4'b1100;
  localparam int DEF_PRIMARY_IDX = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 3;
endpackage

// File: rtl/sensor_sync.sv
// sensor_sync: parametrised-width 2-flop synchroniser for asynchronous level inputs
module sensor_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/sensor_fault_monitor.sv
// sensor_fault_monitor: synchronised, debounced, sticky sensor fault detector with source capture
// Optional saturating fault event counter and fault_count port enabled by SENSOR_MON_COUNT_EN.
module sensor_fault_monitor
  import sensor_mon_pkg::*;
#(
  parameter int                     NUM_SENSORS     = DEF_NUM_SENSORS,
  parameter logic [NUM_SENSORS-1:0] CRIT_MASK       = NUM_SENSORS'(DEF_CRIT_MASK),
  parameter int                     PRIMARY_IDX     = DEF_PRIMARY_IDX,
  parameter logic [NUM_SENSORS-1:0] PAIR_MASK       = NUM_SENSORS'(DEF_PAIR_MASK),
  parameter int                     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef SENSOR_MON_COUNT_EN
  , parameter int                   CNT_W           = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic                   clear,
  output logic                   error,
  output logic                   fault_pending,
  output logic [NUM_SENSORS-1:0] fault_src
`ifdef SENSOR_MON_COUNT_EN
  , output logic [CNT_W-1:0]     fault_count
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // The primary can never be its own pair partner.
  localparam logic [NUM_SENSORS-1:0] PAIR_EFF = PAIR_MASK & ~(NUM_SENSORS'(1) << PRIMARY_IDX);
  logic [NUM_SENSORS-1:0] s_sync, src_q;
  logic                   raw, enter, error_q, pend_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_e                 state_q, state_d;
  sensor_sync #(.W(NUM_SENSORS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sensors),
    .q_o (s_sync)
  );
  assign raw = |(s_sync & CRIT_MASK) | (s_sync[PRIMARY_IDX] & |(s_sync & PAIR_EFF));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (raw) begin
        state_d = (DEBOUNCE_CYCLES == 1) ? FAULT : PENDING;
        cnt_d   = (DEBOUNCE_CYCLES == 1) ? '0 : CW'(1);
      end
      PENDING: if (!raw) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = FAULT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      FAULT: state_d = (clear && !raw) ? IDLE : FAULT;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  assign enter = (state_d == FAULT) && (state_q != FAULT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      error_q <= 1'b0;
      pend_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= state_d == FAULT;
      pend_q  <= state_d == PENDING;
      if (enter) src_q <= s_sync;
    end
  end
  assign error         = error_q;
  assign fault_pending = pend_q;
  assign fault_src     = src_q;
`ifdef SENSOR_MON_COUNT_EN
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else if (enter && count_q != '1) count_q <= count_q + CNT_W'(1);
  end
  assign fault_count = count_q;
`endif
endmodule

// File: tb/tb_sensor_fault_monitor.sv
// tb_sensor_fault_monitor: vector table, corner sequences and randomized run against a run-length model
module tb_sensor_fault_monitor;
  localparam int D = 3;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] sensors = '0;
  logic       error, fault_pending;
  logic [3:0] fault_src;
`ifdef SENSOR_MON_COUNT_EN
  logic [7:0] fault_count;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sensor_fault_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .sensors       (sensors),
    .clear         (clear),
    .error         (error),
    .fault_pending (fault_pending),
    .fault_src     (fault_src)
`ifdef SENSOR_MON_COUNT_EN
    , .fault_count (fault_count)
`endif
  );
  logic [3:0] p1 = '0, p2 = '0, m_src = '0;
  int         run = 0, m_cnt = 0;
  bit         flt = 0;
  function automatic bit raw_of(logic [3:0] s);
    return s[0] | (s[1] & s[2]) | (s[1] & s[3]);
  endfunction
  task automatic model_step(input logic [3:0] s, input logic c, input logic r);
    bit rw;
    if (r) begin
      p1 = '0; p2 = '0; m_src = '0; run = 0; m_cnt = 0; flt = 0;
    end else begin
      rw = raw_of(p2);
      if (flt) begin
        if (c && !rw) begin flt = 0; run = 0; end
      end else if (rw) begin
        run++;
        if (run >= D) begin
          flt = 1; run = 0; m_src = p2;
          if (m_cnt < 255) m_cnt++;
        end
      end else run = 0;
      p2 = p1;
      p1 = s;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic [3:0] s, input logic c, input logic r);
    sensors = s; clear = c; rst = r;
    @(posedge clk);
    model_step(s, c, r);
    #1;
  endtask
  task automatic chk_model(input string tag);
    chk({tag, "_error"}, 32'(error), 32'(flt));
    chk({tag, "_pending"}, 32'(fault_pending), 32'(!flt && run > 0));
    chk({tag, "_src"}, 32'(fault_src), 32'(m_src));
`ifdef SENSOR_MON_COUNT_EN
    chk({tag, "_count"}, 32'(fault_count), 32'(m_cnt));
`endif
  endtask
  typedef struct {
    logic [3:0] s;
    logic       c;
    logic       e;
    logic       p;
    logic [3:0] src;
    int         n;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic [3:0] s, input logic c, input logic e, input logic p,
                     input logic [3:0] src, input int n, input int reps);
    for (int k = 0; k < reps; k++) tbl.push_back('{s, c, e, p, src, n});
  endtask
  initial begin
    logic [3:0] pat;
    int hold;
    add(4'b0001, 0, 0, 0, 4'b0000, 0, 2);
    add(4'b0001, 0, 0, 1, 4'b0000, 0, 2);
    add(4'b0001, 0, 1, 0, 4'b0001, 1, 1);
    add(4'b0000, 0, 1, 0, 4'b0001, 1, 2);
    add(4'b0000, 1, 0, 0, 4'b0001, 1, 1);
    add(4'b0110, 0, 0, 0, 4'b0001, 1, 1);
    add(4'b0000, 0, 0, 0, 4'b0001, 1, 1);
    add(4'b0000, 0, 0, 1, 4'b0001, 1, 1);
    add(4'b0000, 0, 0, 0, 4'b0001, 1, 1);
    add(4'b1010, 0, 0, 0, 4'b0001, 1, 2);
    add(4'b1010, 0, 0, 1, 4'b0001, 1, 2);
    add(4'b1010, 0, 1, 0, 4'b1010, 2, 1);
    add(4'b1010, 1, 1, 0, 4'b1010, 2, 1);
    add(4'b0000, 0, 1, 0, 4'b1010, 2, 2);
    add(4'b0000, 1, 0, 0, 4'b1010, 2, 1);
    add(4'b1100, 0, 0, 0, 4'b1010, 2, 10);
    cyc(4'b0000, 0, 1);
    chk("reset_error", 32'(error), 0);
    chk("reset_pending", 32'(fault_pending), 0);
    chk("reset_src", 32'(fault_src), 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].c, 1'b0);
      chk($sformatf("vec%0d_error", i), 32'(error), 32'(tbl[i].e));
      chk($sformatf("vec%0d_pending", i), 32'(fault_pending), 32'(tbl[i].p));
      chk($sformatf("vec%0d_src", i), 32'(fault_src), 32'(tbl[i].src));
`ifdef SENSOR_MON_COUNT_EN
      chk($sformatf("vec%0d_count", i), 32'(fault_count), 32'(tbl[i].n));
`endif
    end
    cyc(4'b0000, 0, 1);
    repeat (4) cyc(4'b0001, 0, 0);
    chk("mid_pending", 32'(fault_pending), 1);
    cyc(4'b0001, 0, 1);
    chk("rst_pend_error", 32'(error), 0);
    chk("rst_pend_pending", 32'(fault_pending), 0);
    repeat (4) cyc(4'b0001, 0, 0);
    chk("restart_error_early", 32'(error), 0);
    chk("restart_pending", 32'(fault_pending), 1);
    cyc(4'b0001, 0, 0);
    chk("restart_error", 32'(error), 1);
    chk("restart_src", 32'(fault_src), 4'b0001);
    cyc(4'b0001, 0, 1);
    chk("rst_fault_error", 32'(error), 0);
    chk("rst_fault_pending", 32'(fault_pending), 0);
    chk("rst_fault_src", 32'(fault_src), 0);
`ifdef SENSOR_MON_COUNT_EN
    chk("rst_fault_count", 32'(fault_count), 0);
    cyc(4'b0000, 0, 1);
    for (int i = 0; i < 258; i++) begin
      repeat (5) cyc(4'b0001, 0, 0);
      repeat (2) cyc(4'b0000, 0, 0);
      cyc(4'b0000, 1, 0);
      if (i == 253) chk("count_254", 32'(fault_count), 254);
      if (i == 254) chk("count_255", 32'(fault_count), 255);
    end
    chk("count_saturated", 32'(fault_count), 255);
    chk("sat_error_cleared", 32'(error), 0);
`endif
    cyc(4'b0000, 0, 1);
    chk_model("rand_reset");
    hold = 0;
    pat = '0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        pat = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 7);
      end
      hold--;
      cyc(pat, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
      chk_model($sformatf("rand%0d", i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
